// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module      : video_pkg
// Description : Shared video timing constants, count/pixel types and the
//               pixel bundle carried between the multiplexer and effect stages.
//               Also holds the colour-depth reduction helper.
// Revision    : 1.0 - initial release
// ============================================================================
package video_pkg;

    localparam int H_ACTIVE = 1280;
    localparam int V_ACTIVE = 720;

    typedef logic [10:0] hcount_t;
    typedef logic [9:0]  vcount_t;
    typedef logic [23:0] pixel_t;

    typedef struct packed {
        hcount_t h;
        vcount_t v;
        logic    active;
        pixel_t  pixel;
    } video_bus_t;

    // Keep the top 'keep' bits of each 8-bit channel, zero the rest.
    function automatic pixel_t crush_pixel(input pixel_t p, input logic [3:0] keep);
        logic [7:0] m;
        m = 8'hFF << (4'd8 - keep);
        return p & {m, m, m};
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_buffer_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_buffer_ram
// Description : Single-clock simple dual-port RAM holding one video line.
//               One write port, one read port with a registered output
//               (1-cycle read latency). Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module line_buffer_ram #(
    parameter int DEPTH  = video_pkg::H_ACTIVE,
    parameter int WIDTH  = 24,
    parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // Write port and registered read port share the single clock.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[waddr] <= wdata;
        end
        if (re) begin
            r_rdata <= r_mem[raddr];
        end
    end

    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/video_crush_fx.sv
`default_nettype none
// ============================================================================
// Module      : video_crush_fx
// Description : Pixelation / colour-crush effect. NxN block sample-and-hold
//               (horizontal hold register + vertical repeat from a one-line
//               buffer) followed by per-channel colour-depth reduction.
//               Settings are latched at frame start; fixed 2-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
module video_crush_fx #(
    parameter int H_ACTIVE = video_pkg::H_ACTIVE,
    parameter int V_ACTIVE = video_pkg::V_ACTIVE
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  crush_amount,
    input  logic [10:0] h_count_in,
    input  logic [9:0]  v_count_in,
    input  logic        active_draw_in,
    input  logic [23:0] pixel_in,
    output logic [10:0] h_count_out,
    output logic [9:0]  v_count_out,
    output logic        active_draw_out,
    output logic [23:0] pixel_out
);
    import video_pkg::*;

    localparam int          LB_AW   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam logic [10:0] c_H_LIM = 11'(H_ACTIVE);
    localparam logic [9:0]  c_V_LIM = 10'(V_ACTIVE);

    // Latched per-frame settings: block size 1..16, bits kept 1..8.
    logic [4:0]  r_blk;
    logic [3:0]  r_keep;

    // Block phase counters (registered) and their values for the current input.
    logic [3:0]  r_h_phase;
    logic [3:0]  r_v_phase;
    logic [3:0]  w_h_phase;
    logic [3:0]  w_v_phase;

    logic        w_line_start;
    logic        w_frame_start;
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_src_row;
    pixel_t      w_held;
    logic        w_we;
    logic        w_re;
    logic [LB_AW-1:0] w_addr;
    pixel_t      w_rdata;
    pixel_t      w_sel;

    // Stage 1 registers.
    hcount_t     r1_h;
    vcount_t     r1_v;
    logic        r1_active;
    logic        r1_src;
    pixel_t      r_hold;

    // Stage 2 (output) register.
    video_bus_t  r_out;

    // Low crush_amount bits do not influence the effect.
    logic        w_unused_amt;
    assign w_unused_amt = ^crush_amount[5:0];

    // Phase and row-type decode for the pixel currently at the input.
    always_comb begin
        w_line_start  = (h_count_in == 11'd0);
        w_frame_start = w_line_start && (v_count_in == 10'd0);
        w_h_wrap      = ({1'b0, r_h_phase} >= (r_blk - 5'd1));
        w_v_wrap      = ({1'b0, r_v_phase} >= (r_blk - 5'd1));

        if (w_line_start || w_h_wrap) begin
            w_h_phase = 4'd0;
        end else begin
            w_h_phase = r_h_phase + 4'd1;
        end

        if (w_frame_start) begin
            w_v_phase = 4'd0;
        end else if (w_line_start) begin
            w_v_phase = w_v_wrap ? 4'd0 : (r_v_phase + 4'd1);
        end else begin
            w_v_phase = r_v_phase;
        end

        w_src_row = (w_v_phase == 4'd0);
        w_held    = (w_h_phase == 4'd0) ? pixel_in : r_hold;
        w_we      = w_src_row && active_draw_in && (h_count_in < c_H_LIM);
        w_re      = !w_src_row && (h_count_in < c_H_LIM);
        w_addr    = h_count_in[LB_AW-1:0];
        w_sel     = r1_src ? r_hold : w_rdata;
    end

    // Latch effect settings once per frame so the picture never tears.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_blk  <= 5'd1;
            r_keep <= 4'd8;
        end else if (w_frame_start) begin
            r_blk  <= 5'd1 + {1'b0, crush_amount[9:6]};
            r_keep <= 4'd8 - {1'b0, crush_amount[9:7]};
        end
    end

    // Track horizontal and vertical position within the current block.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_h_phase <= 4'd0;
            r_v_phase <= 4'd0;
        end else begin
            r_h_phase <= w_h_phase;
            r_v_phase <= w_v_phase;
        end
    end

    // Stage 1: capture timing, sample-and-hold the block's first pixel.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r1_h      <= '0;
            r1_v      <= '0;
            r1_active <= 1'b0;
            r1_src    <= 1'b0;
            r_hold    <= '0;
        end else begin
            r1_h      <= h_count_in;
            r1_v      <= v_count_in;
            r1_active <= active_draw_in;
            r1_src    <= w_src_row;
            if (w_src_row && (w_h_phase == 4'd0)) begin
                r_hold <= pixel_in;
            end
        end
    end

    // Source rows store their held pixels; repeat rows replay them.
    line_buffer_ram #(
        .DEPTH  (H_ACTIVE),
        .WIDTH  (24),
        .ADDR_W (LB_AW)
    ) u_line_buffer (
        .clk    (clk),
        .we     (w_we),
        .waddr  (w_addr),
        .wdata  (w_held),
        .re     (w_re),
        .raddr  (w_addr),
        .rdata  (w_rdata)
    );

    // Stage 2: quantise and blank outside the active area.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out <= '0;
        end else begin
            r_out.h      <= r1_h;
            r_out.v      <= r1_v;
            r_out.active <= r1_active;
            r_out.pixel  <= r1_active ? crush_pixel(w_sel, r_keep) : 24'h0;
        end
    end

    // Active video must lie inside the configured raster.
    always_ff @(posedge clk) begin
        if (rst_n && active_draw_in) begin
            assert (v_count_in < c_V_LIM && h_count_in < c_H_LIM);
        end
    end

    assign h_count_out     = r_out.h;
    assign v_count_out     = r_out.v;
    assign active_draw_out = r_out.active;
    assign pixel_out       = r_out.pixel;

endmodule
`default_nettype wire

// File: tb/tb_video_crush_fx.sv
`default_nettype none
// ============================================================================
// Module      : tb_video_crush_fx
// Description : Directed bench for video_crush_fx on a reduced 30x20 raster
//               (37x24 total) with hand-derived expected pixels per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_video_crush_fx;

    localparam int HA = 30;
    localparam int VA = 20;
    localparam int HT = 37;
    localparam int VT = 24;

    localparam int P_RAMP = 0;
    localparam int P_HV   = 1;
    localparam int P_HV4  = 2;
    localparam int P_B16  = 3;

    localparam int M_ID    = 0;
    localparam int M_B4    = 1;
    localparam int M_B16   = 2;
    localparam int M_B16HV = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  crush_amount = '0;
    logic [10:0] h_count_in = '0;
    logic [9:0]  v_count_in = '0;
    logic        active_draw_in = 1'b0;
    logic [23:0] pixel_in = '0;
    logic [10:0] h_count_out;
    logic [9:0]  v_count_out;
    logic        active_draw_out;
    logic [23:0] pixel_out;

    int vecs = 0;
    int miscompares = 0;

    // last applied vector (l_*) and the one the outputs reflect (q_*)
    logic [10:0] l_h = '0, q_h;
    logic [9:0]  l_v = '0, q_v;
    logic        l_a = 1'b0, q_a;
    logic [23:0] l_pix = '0, q_pix;
    logic        l_rst_n = 1'b0, q_rst_n;
    int          l_mode = 0, q_mode;

    video_crush_fx #(
        .H_ACTIVE (HA),
        .V_ACTIVE (VA)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .crush_amount    (crush_amount),
        .h_count_in      (h_count_in),
        .v_count_in      (v_count_in),
        .active_draw_in  (active_draw_in),
        .pixel_in        (pixel_in),
        .h_count_out     (h_count_out),
        .v_count_out     (v_count_out),
        .active_draw_out (active_draw_out),
        .pixel_out       (pixel_out)
    );

    always #5 clk = ~clk;

    function automatic logic [23:0] expect_pix(input int m, input logic [10:0] h,
                                               input logic [9:0] v, input logic a,
                                               input logic [23:0] p);
        logic [7:0] bh;
        logic [7:0] bv;
        if (!a) return 24'h0;
        bh = {h[7:2], 2'b00};
        bv = (v >= 10'd4 && v < 10'd8) ? 8'h00 : {v[7:2], 2'b00};
        case (m)
            M_ID:    return p;
            M_B4:    return {bh & 8'hFE, bv & 8'hFE, 8'hFE};
            M_B16:   return (v < 10'd16) ? 24'h008080 : 24'h808080;
            M_B16HV: return 24'h000080;
            default: return 24'h0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s h=%0d v=%0d observed=%h expected=%h", tag, q_h, q_v, obs, exp);
        end
    endtask

    task automatic tick(input logic [10:0] h, input logic [9:0] v, input logic a,
                        input logic [23:0] p, input logic r, input int m);
        logic zero;
        q_h = l_h; q_v = l_v; q_a = l_a; q_pix = l_pix; q_rst_n = l_rst_n; q_mode = l_mode;
        l_h = h; l_v = v; l_a = a; l_pix = p; l_rst_n = r; l_mode = m;
        h_count_in = h; v_count_in = v; active_draw_in = a; pixel_in = p; rst_n = r;
        @(posedge clk);
        #1;
        zero = !r || !q_rst_n;
        check("pixel",  pixel_out, zero ? 24'h0 : expect_pix(q_mode, q_h, q_v, q_a, q_pix));
        check("h_out",  24'(h_count_out), zero ? 24'h0 : 24'(q_h));
        check("v_out",  24'(v_count_out), zero ? 24'h0 : 24'(q_v));
        check("active", 24'(active_draw_out), zero ? 24'h0 : 24'(q_a));
    endtask

    task automatic frame(input int pat, input int mode, input int chg_v,
                         input logic [9:0] chg_val, input int rst_v);
        for (int v = 0; v < VT; v++) begin
            for (int h = 0; h < HT; h++) begin
                logic        a;
                logic [23:0] p;
                logic        r;
                int          m;
                if (v == chg_v && h == 0) crush_amount = chg_val;
                a = (h < HA) && (v < VA) && !(pat == P_HV4 && v == 4);
                case (pat)
                    P_RAMP:  p = 24'(h);
                    P_HV:    p = {8'(h), 8'(v), 8'hFF};
                    P_HV4:   p = (v == 4) ? 24'hFFFFFF : {8'(h), 8'(v), 8'hFF};
                    default: p = (v == 0 && (h % 16) == 0) ? 24'h7F80FF : 24'hFFFFFF;
                endcase
                if (h >= HA || v >= VA) p = 24'hABCDEF;
                r = !(v == rst_v && h >= 10 && h < 13);
                m = (rst_v >= 0 && (v > rst_v || (v == rst_v && h >= 10))) ? M_ID : mode;
                tick(11'(h), 10'(v), a, p, r, m);
            end
        end
    endtask

    initial begin
        // reset with blanking inputs
        for (int i = 0; i < 4; i++) begin
            tick(11'(HT - 4 + i), 10'(VT - 1), 1'b0, 24'h123456, 1'b0, M_ID);
        end
        // identity ramp; crush_amount changes mid-frame and must not take effect yet
        frame(P_RAMP, M_ID, 10, 10'h0C0, -1);
        // 4x4 blocks, 7 bits; row 4 blanked must not disturb repeat rows 5..7
        frame(P_HV4, M_B4, 12, 10'h3FF, -1);
        // 16x16 blocks, 1 bit; truncated last block, repeat of row 0
        frame(P_B16, M_B16, -1, 10'h3FF, -1);
        // reset mid-line at row 5: identity until the next frame start
        frame(P_HV, M_B16HV, -1, 10'h3FF, 5);
        // settings restored at the following frame
        frame(P_HV, M_B16HV, -1, 10'h3FF, -1);
        for (int i = 0; i < 2; i++) begin
            tick(11'(HA + i), 10'(VA), 1'b0, 24'hABCDEF, 1'b1, M_ID);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
